// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the iterative multiply/divide unit.
//   - MD_WIDTH : default operand / HI / LO width
//   - MD_CNT_W : iteration counter width
//   - md_op_e  : operation encodings presented on the op port
//   - md_state_e : controller states
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/add_sub_w.sv
// add_sub_w: WIDTH-bit ripple-carry adder/subtractor built from a chain of
// full-adder cells.
//   a, b : operands
//   sub  : 0 -> a + b, 1 -> a - b (b inverted, carry-in forced to 1)
//   sum  : WIDTH-bit result
//   cout : carry out of the top cell (for subtract, 1 means no borrow)
module add_sub_w
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_x;

  assign b_x      = b ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b_x[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_x[i]) | (a[i] & carry[i]) | (b_x[i] & carry[i]);
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One add/subtract per cycle through add_sub_w; 33 busy cycles per operation.
//   clk, rst      : clock, synchronous active-high reset
//   start, op     : launch an operation (sampled only when idle)
//   rs_val/rt_val : multiplicand/multiplier or dividend/divisor
//   mthi/mtlo     : write wdata to HI/LO when idle and no start
//   busy          : operation in flight
//   done          : one-cycle pulse once HI/LO hold the new result
//   div_by_zero   : pulses with done when the divisor was zero
//   hi, lo        : architectural HI/LO registers
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e state, state_n;
  logic [CNT_W-1:0] count;

  // Working register: {upper, lower}. Multiply: {partial sum, multiplier};
  // divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   rs_raw;
  logic               is_div_q;
  logic               sgn_diff_q;
  logic               rs_neg_q;
  logic               dbz_q;

  // Launch-time operand conditioning.
  md_op_e             op_in;
  logic               is_div_in;
  logic               is_signed_in;
  logic               rs_neg;
  logic               rt_neg;
  logic signed [WIDTH-1:0] rs_s;
  logic signed [WIDTH-1:0] rt_s;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;

  assign op_in        = md_op_e'(op);
  assign is_div_in    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign is_signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign rs_s         = rs_val;
  assign rt_s         = rt_val;
  assign rs_neg       = is_signed_in && rs_val[WIDTH-1];
  assign rt_neg       = is_signed_in && rt_val[WIDTH-1];
  assign rs_mag       = rs_neg ? WIDTH'(-rs_s) : rs_val;
  assign rt_mag       = rt_neg ? WIDTH'(-rt_s) : rt_val;

  assign busy = (state != IDLE);

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (count == CNT_W'(WIDTH - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Shared add/sub path: multiply adds the multiplicand into the upper half,
  // divide trial-subtracts the divisor from the left-shifted remainder.
  logic [2*WIDTH-1:0] div_sh;
  logic [WIDTH-1:0]   as_a;
  logic [WIDTH-1:0]   as_sum;
  logic               as_cout;

  assign div_sh = {acc[2*WIDTH-2:0], 1'b0};
  assign as_a   = is_div_q ? div_sh[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  add_sub_w #(.WIDTH(WIDTH)) u_add_sub (
    .a    (as_a),
    .b    (opb),
    .sub  (is_div_q),
    .sum  (as_sum),
    .cout (as_cout)
  );

  always_comb begin
    acc_n = acc;
    if (is_div_q) begin
      // The bit shifted out of the remainder is the implicit WIDTH+1-th bit:
      // if set, the shifted remainder certainly exceeds the divisor.
      if (acc[2*WIDTH-1] || as_cout)
        acc_n = {as_sum, div_sh[WIDTH-1:1], 1'b1};
      else
        acc_n = {div_sh[2*WIDTH-1:1], 1'b0};
    end else begin
      if (acc[0])
        acc_n = {as_cout, as_sum, acc[WIDTH-1:1]};
      else
        acc_n = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Sign fixup and divide-by-zero override.
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [WIDTH-1:0]   quo_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]          res_hi;
  logic [WIDTH-1:0]          res_lo;

  assign prod_s = acc;
  assign quo_s  = acc[WIDTH-1:0];
  assign rem_s  = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    if (!is_div_q) begin
      if (sgn_diff_q) begin
        res_hi = WIDTH'((-prod_s) >>> WIDTH);
        res_lo = WIDTH'(-prod_s);
      end
    end else if (dbz_q) begin
      res_hi = rs_raw;
      res_lo = '1;
    end else begin
      res_lo = sgn_diff_q ? WIDTH'(-quo_s) : acc[WIDTH-1:0];
      res_hi = rs_neg_q   ? WIDTH'(-rem_s) : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Start takes priority over any MTHI/MTLO in the same cycle.
            count      <= '0;
            acc        <= {{WIDTH{1'b0}}, (is_div_in ? rs_mag : rt_mag)};
            opb        <= is_div_in ? rt_mag : rs_mag;
            rs_raw     <= rs_val;
            is_div_q   <= is_div_in;
            sgn_diff_q <= rs_neg ^ rt_neg;
            rs_neg_q   <= rs_neg;
            dbz_q      <= is_div_in && (rt_val == '0);
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          acc   <= acc_n;
          count <= count + 1'b1;
        end
        FIX: begin
          hi          <= res_hi;
          lo          <= res_lo;
          done        <= 1'b1;
          div_by_zero <= dbz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dbz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    e_dbz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = 64'(sa * sb); e_hi = p[63:32]; e_lo = p[31:0]; end
      2'b01: begin p = 64'(a) * 64'(b); e_hi = p[63:32]; e_lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e_dbz = 1'b1; e_hi = a; e_lo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          e_lo = q[31:0]; e_hi = r[31:0];
        end else begin
          e_lo = a / b; e_hi = a % b;
        end
      end
    endcase
  endtask

  // disturb: 0 none, 1 start/mthi/mtlo pulses while busy, 2 mthi/mtlo with start
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int disturb);
    logic [31:0] e_hi, e_lo, h0, l0;
    logic        e_dbz;
    int          n;
    model(o, a, b, e_hi, e_lo, e_dbz);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    if (disturb == 2) begin
      mthi = 1'b1; mtlo = 1'b1; wdata = ~(h0 ^ 32'h5A5A_0F0F);
    end
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk({tag, "_busy_launch"}, 64'(busy), 64'd1);
    chk({tag, "_done_low"}, 64'(done), 64'd0);
    n = 0;
    while (!done && n < 40) begin
      if (disturb == 1 && n == 5) begin
        start = 1'b1; op = 2'b10; rs_val = $urandom; rt_val = $urandom;
        mtlo = 1'b1; mthi = 1'b1; wdata = 32'h0000_1234;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (n == 16) begin
        chk({tag, "_hold_hi"}, 64'(hi), 64'(h0));
        chk({tag, "_hold_lo"}, 64'(lo), 64'(l0));
      end
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(e_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(e_lo));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e_dbz));
  endtask

  initial begin
    int n;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic        seen_done;

    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    // MTHI/MTLO while idle, both in one cycle
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_idle", 64'(hi), 64'h0000_0000_CAFE_F00D);
    chk("mtlo_idle", 64'(lo), 64'h0000_0000_CAFE_F00D);
    mtlo = 1'b1; wdata = 32'h0000_0042;
    @(posedge clk); #1;
    mtlo = 1'b0;
    chk("mtlo_only_lo", 64'(lo), 64'h42);
    chk("mtlo_only_hi", 64'(hi), 64'h0000_0000_CAFE_F00D);

    // Directed cases; consecutive calls launch in the done cycle
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    run_op("multu",     2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_zero", 2'b11, 32'h0000_0007, 32'h0000_0000, 0);
    run_op("div_zero",  2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op("busy_ign",  2'b01, 32'h0000_0003, 32'h0000_0005, 1);
    run_op("start_win", 2'b00, 32'h0001_0000, 32'hFFFF_0000, 2);

    // done lasts exactly one cycle
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 4 == 1) ra = -ra;
      run_op("rand", ro, ra, rb, 0);
    end

    // Reset while CALC count=10 aborts the operation
    start = 1'b1; op = 2'b01; rs_val = 32'h1234_5678; rt_val = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    seen_done = done;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);

    // Unit is usable again after the abort
    run_op("post_abort", 2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit in the EX stage of the five-stage MIPS core; executes MULT, MULTU, DIV and DIVU and owns the architectural HI/LO registers. It consumes the sum/carry produced by the team's full-adder cell: one ripple add/subtract per cycle over a WIDTH-bit datapath. Busy drives the hazard unit's stall for MFHI/MFLO and for back-to-back mult/div.

Parameters:
WIDTH, 32, operand width and HI/LO width. The bench exercises only 32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_val  input  WIDTH  multiplicand / dividend
rt_val  input  WIDTH  multiplier / divisor
mthi  input  1  write wdata to HI (accepted only when idle)
mtlo  input  1  write wdata to LO (accepted only when idle)
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight
done  output  1  one-cycle pulse; HI/LO updated
div_by_zero  output  1  pulses with done when a DIV/DIVU divisor was 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: one clock; synchronous, active-high. State=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; iteration counter=0.
- Reset mid-operation aborts the operation immediately. No done pulse follows. HI/LO are cleared.
- FSM states:
  - IDLE: start=1 at edge E0 latches op and operands, goes to CALC, count=0.
  - CALC: edges E1..E32 each perform one iteration; at E32 (count=WIDTH-1) go to FIX.
  - FIX: at E33 apply sign fixup, write hi/lo, pulse done, return to IDLE.
- Timing: busy=1 in the cycles following E0 through E33, i.e. 33 cycles. done=1 for exactly the cycle after E33, when busy=0 again.
- A new start is legal in the same cycle done is high.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitude at E0; sign flags are latched.
  - MULT: negate the 2*WIDTH product if the sign flags differ.
  - DIV: negate the quotient if the sign flags differ. The remainder takes the dividend's sign.
- Multiply: shift-add. Each iteration: if the product LSB is 1, add the multiplicand to the upper half (WIDTH+1-bit sum keeps the carry), then shift right one. Result: HI=product[2W-1:W], LO=product[W-1:0].
- Divide: restoring. Each iteration: shift {rem,quo} left, trial subtract the divisor via the add/sub path, and keep the result if non-negative (quotient bit 1). Result: HI=remainder, LO=quotient.
- Divide by zero:
  - Full latency is still consumed and the sign fixup is bypassed.
  - LO=all ones, HI=rs_val as latched.
  - div_by_zero=1 alongside done.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. This falls out of the magnitude arithmetic and needs no special case.
- start while busy=1 is ignored (no queueing). Latched operands are unaffected.
- mthi/mtlo:
  - When idle, write at the edge; they are independent, so both may write in one cycle.
  - Ignored while busy.
  - If start=1 in the same idle cycle, start wins and the writes are dropped.
- hi/lo hold their value between completions and writes. They never show intermediate values.

Decomposition:
- Package md_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum (IDLE, CALC, FIX), WIDTH default, and counter width $clog2(WIDTH).
- Sub-module add_sub_w: WIDTH-bit ripple add/subtract built from a chain of the full-adder cells. Subtract = invert B and carry-in 1. Outputs sum and carry-out.
- The FSM, operand registers and sign fixup stay in mult_div_unit.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=0x00000003 -> done exactly 34 cycles after the start cycle (33 busy cycles); hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFE, rt=0x00000003 -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=0x00000007, div_by_zero=1 with done.
- Control-path checks:
  - start pulses while busy are ignored.
  - mtlo=1 with wdata=0x1234 while busy leaves lo unchanged.
  - rst asserted at CALC count=10 -> next cycle busy=0, hi=lo=0, and no done.
